// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared constants and FSM state type for the Fibonacci index decoder
//
// Purpose: index width, largest 32-bit Fibonacci index, and the decoder state enum.
// Ports: none (package).
package fib_pkg;

  localparam int FIB_IDX_W   = 6;
  localparam int FIB_MAX_IDX = 47;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } fib_state_t;

endpackage

// File: rtl/fib_pair_gen.sv
// rtl/fib_pair_gen.sv - prev/curr Fibonacci register pair with load and advance controls
//
// Purpose: holds two consecutive Fibonacci terms; load seeds F(0)/F(1), advance steps by one.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, clears both terms
//   i_load     seed prev=F(0), curr=F(1)
//   i_advance  prev<=curr, curr<=prev+curr
//   o_prev     current term F(idx)
//   o_curr     next term F(idx+1)
module fib_pair_gen #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_prev,
  output logic [WIDTH-1:0] o_curr
);

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_curr;
  logic [WIDTH-1:0] w_sum;

  // Sum is kept at WIDTH bits; the carry out is discarded. The only wrapped
  // value ever produced lands in curr after reaching F(47), and the decoder
  // stops before it could be shifted into prev and compared.
  assign w_sum = r_prev + r_curr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_curr <= '0;
    end else if (i_load) begin
      r_prev <= '0;
      r_curr <= WIDTH'(1);
    end else if (i_advance) begin
      r_prev <= r_curr;
      r_curr <= w_sum;
    end
  end

  assign o_prev = r_prev;
  assign o_curr = r_curr;

endmodule

// File: rtl/fibonacci_index_decoder.sv
// rtl/fibonacci_index_decoder.sv - finds the Fibonacci index of a 32-bit target value
//
// Purpose: accepts a target, walks F(0), F(1), ... one term per cycle and reports
//          whether the target is a Fibonacci number and the matching (or next larger) index.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   in_valid    request present
//   in_ready    ready for a request (IDLE only)
//   in_value    target value
//   out_valid   result present (DONE only)
//   out_ready   consumer takes the result
//   out_is_fib  target equals some F(k)
//   out_index   k on a hit, index of smallest larger term on a miss (48 past F(47))
module fibonacci_index_decoder
  import fib_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_is_fib,
  output logic [FIB_IDX_W-1:0] out_index
);

  fib_state_t             r_state;
  fib_state_t             w_next_state;
  logic [WIDTH-1:0]       r_target;
  logic [FIB_IDX_W-1:0]   r_idx;
  logic                   r_out_is_fib;
  logic [FIB_IDX_W-1:0]   r_out_index;

  logic [WIDTH-1:0]       w_prev;
  logic [WIDTH-1:0]       w_curr;
  logic                   w_load;
  logic                   w_advance;
  logic                   w_resolve;
  logic                   w_hit;
  logic [FIB_IDX_W-1:0]   w_res_index;
  logic                   w_eq;
  logic                   w_gt;

  fib_pair_gen #(.WIDTH(WIDTH)) u_pair (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_advance (w_advance),
    .o_prev    (w_prev),
    .o_curr    (w_curr)
  );

  assign w_eq = (w_prev == r_target);
  assign w_gt = (w_prev >  r_target);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_resolve    = 1'b0;
    w_hit        = 1'b0;
    w_res_index  = '0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_next_state = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (w_eq) begin
          w_resolve    = 1'b1;
          w_hit        = 1'b1;
          w_res_index  = r_idx;
          w_next_state = ST_DONE;
        end else if (w_gt) begin
          w_resolve    = 1'b1;
          w_res_index  = r_idx;
          w_next_state = ST_DONE;
        end else if (r_idx == FIB_IDX_W'(FIB_MAX_IDX)) begin
          // Target lies above F(47): the next term does not fit in 32 bits.
          w_resolve    = 1'b1;
          w_res_index  = FIB_IDX_W'(FIB_MAX_IDX + 1);
          w_next_state = ST_DONE;
        end else begin
          w_advance    = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target     <= '0;
      r_idx        <= '0;
      r_out_is_fib <= 1'b0;
      r_out_index  <= '0;
    end else begin
      if (w_load) begin
        r_target     <= in_value;
        r_idx        <= '0;
        r_out_is_fib <= 1'b0;
        r_out_index  <= '0;
      end else if (w_advance) begin
        r_idx <= r_idx + FIB_IDX_W'(1);
      end
      if (w_resolve) begin
        r_out_is_fib <= w_hit;
        r_out_index  <= w_res_index;
      end
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_is_fib = r_out_is_fib;
  assign out_index  = r_out_index;

endmodule

// File: tb/tb_fibonacci_index_decoder.sv
// tb/tb_fibonacci_index_decoder.sv - self-checking bench for fibonacci_index_decoder
module tb_fibonacci_index_decoder;

  typedef struct {
    logic [31:0] value;
    logic        is_fib;
    logic [5:0]  idx;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_fib;
  logic [5:0]  out_index;

  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  fibonacci_index_decoder #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_is_fib (out_is_fib),
    .out_index  (out_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the sequence in 64-bit arithmetic so no term ever wraps.
  function automatic exp_t model(input logic [31:0] v);
    exp_t        e;
    longint      a;
    longint      b;
    longint      t;
    bit          found;
    a = 0;
    b = 1;
    found = 0;
    e.value  = v;
    e.is_fib = 1'b0;
    e.idx    = 6'd48;
    for (int k = 0; k <= 47; k++) begin
      if (!found) begin
        if (a == longint'(v)) begin
          e.is_fib = 1'b1;
          e.idx    = 6'(k);
          found    = 1;
        end else if (a > longint'(v)) begin
          e.idx    = 6'(k);
          found    = 1;
        end else begin
          t = a + b;
          a = b;
          b = t;
        end
      end
    end
    e.lat = (e.idx == 6'd48) ? 48 : int'(e.idx) + 1;
    return e;
  endfunction

  // Accept one request, measure latency, pop the scoreboard, then release it
  // (after holding out_ready low for 'hold' cycles if requested).
  task automatic run_req(input logic [31:0] v, input int hold);
    exp_t e;
    int   guard;
    int   lat;
    bit   got;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    out_ready = (hold > 0) ? 1'b0 : 1'b1;
    in_valid  = 1'b1;
    in_value  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = $urandom;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!got && lat < 100) in_value = $urandom;
      if (out_valid) got = 1;
    end
    check("out_valid_seen", got, 1'b1);
    e = sb.pop_front();
    check($sformatf("is_fib[%0d]", e.value), out_is_fib, e.is_fib);
    check($sformatf("index[%0d]", e.value), out_index, e.idx);
    check($sformatf("latency[%0d]", e.value), lat, e.lat);
    check("in_ready_done", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_is_fib", out_is_fib, e.is_fib);
      check("bp_index", out_index, e.idx);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", out_valid, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
  endtask

  task automatic push_exp(input logic [31:0] v, input logic f, input logic [5:0] k, input int lat);
    exp_t e;
    e.value  = v;
    e.is_fib = f;
    e.idx    = k;
    e.lat    = lat;
    sb.push_back(e);
  endtask

  initial begin
    longint fa;
    longint fb;
    longint ft;
    bit     stray;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_value  = 32'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_is_fib", out_is_fib, 1'b0);
    check("rst_index", out_index, 6'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-derived expectations.
    push_exp(32'd0, 1'b1, 6'd0, 1);            run_req(32'd0, 0);
    push_exp(32'd13, 1'b1, 6'd7, 8);           run_req(32'd13, 0);
    push_exp(32'd1, 1'b1, 6'd1, 2);            run_req(32'd1, 0);
    push_exp(32'd14, 1'b0, 6'd8, 9);           run_req(32'd14, 0);
    push_exp(32'd2971215073, 1'b1, 6'd47, 48); run_req(32'd2971215073, 0);
    push_exp(32'hFFFFFFFF, 1'b0, 6'd48, 48);   run_req(32'hFFFFFFFF, 0);
    push_exp(32'd21, 1'b1, 6'd8, 9);           run_req(32'd21, 10);

    // Reset in the middle of a long search.
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 32'd2971215073;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_is_fib", out_is_fib, 1'b0);
    check("abort_index", out_index, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stray = 1;
    end
    check("abort_no_result", stray, 1'b0);
    push_exp(32'd5, 1'b1, 6'd5, 6);            run_req(32'd5, 0);

    // Sweep every 32-bit term and term+1 against the reference model.
    fa = 0;
    fb = 1;
    for (int k = 0; k <= 47; k++) begin
      sb.push_back(model(32'(fa)));
      run_req(32'(fa), 0);
      sb.push_back(model(32'(fa + 1)));
      run_req(32'(fa + 1), 0);
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fibonacci_index_decoder.md
FIBONACCI_INDEX_DECODER -- requirements
Module: fibonacci_index_decoder

Interface
REQ-001 Parameter: WIDTH, default 32, data width of in_value. Fixed at 32 for this release.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request carries a target value.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_value  input  32  unsigned target value to decode.
REQ-007 out_valid  output  1  result is available.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 out_is_fib  output  1  1 when the target equals some F(k).
REQ-010 out_index  output  6  on a hit, the index k; on a miss, the index of the smallest Fibonacci number greater than the target.

Function
REQ-011 Sequence definition: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2). F(47)=2971215073 is the largest 32-bit term.
REQ-012 On a hit for value 1, the block SHALL report index 1, not index 2.
REQ-013 FSM states: IDLE, SEARCH, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE. out_valid SHALL be 1 only in DONE.
REQ-015 IDLE transition: a request is accepted on an edge with in_valid && in_ready. On acceptance:
  - latch the target;
  - load prev=F(0), curr=F(1), idx=0;
  - enter SEARCH.
REQ-016 SEARCH, one comparison per cycle on prev=F(idx):
  - equal to target: hit, out_is_fib=1, out_index=idx, enter DONE;
  - greater than target: miss, out_is_fib=0, out_index=idx, enter DONE;
  - otherwise: prev<=curr, curr<=prev+curr, idx<=idx+1.
REQ-017 Overflow rule, applied when idx==47 and F(47)<target: miss, out_is_fib=0, out_index=48, enter DONE. The 33rd sum bit SHALL never be used as data.
REQ-018 Latency: out_valid SHALL rise exactly k+1 cycles after the accept edge, where k is the reported out_index. For the overflow miss, that is 48 cycles.
REQ-019 DONE: out_is_fib and out_index SHALL stay stable while out_valid=1 && out_ready=0.
REQ-020 DONE exit: on out_valid && out_ready, go to IDLE. in_ready becomes 1 the following cycle; there is no back-to-back accept in the release cycle.
REQ-021 in_valid and in_value SHALL be ignored outside IDLE; in_value changes during SEARCH SHALL NOT affect the result.

Reset
REQ-022 While rst=1 at a clock edge:
  - state SHALL go to IDLE;
  - in_ready SHALL be 1; out_valid, out_is_fib and out_index SHALL be 0;
  - prev, curr, idx and target SHALL be 0.
REQ-023 Reset asserted during SEARCH or DONE SHALL abort the request with no result emitted. Reset SHALL take priority over every handshake in the same cycle.

Structure
REQ-024 A shared package fib_pkg SHALL hold:
  - FIB_IDX_W=6;
  - FIB_MAX_IDX=47;
  - the FSM state enum.
REQ-025 The prev/curr register pair with load and advance controls SHALL be a sub-module, fib_pair_gen. The decoder instantiates it once and owns the FSM and compare logic.
REQ-026 Outputs SHALL be registered; there SHALL be no combinational path from in_* or out_ready to out_is_fib or out_index.

Verification
REQ-027 Directed scenarios, out_ready=1 unless stated:
  - in_value=0 -> out_is_fib=1, out_index=0, out_valid 1 cycle after accept.
  - in_value=13 -> out_is_fib=1, out_index=7, latency 8. in_value=1 -> out_index=1, latency 2.
  - in_value=14 -> out_is_fib=0, out_index=8 (F(8)=21), latency 9.
  - in_value=2971215073 -> out_is_fib=1, out_index=47, latency 48. in_value=32'hFFFFFFFF -> out_is_fib=0, out_index=48, latency 48.
  - Backpressure: in_value=21, out_ready held 0 for 10 cycles -> out_valid, out_is_fib=1 and out_index=8 stay stable; in_ready=0 throughout. out_ready=1 -> IDLE, in_ready=1 next cycle.
  - Reset mid-SEARCH: rst pulsed 5 cycles after accepting in_value=2971215073 -> next cycle in IDLE with all outputs at reset values. A new request for 5 -> out_index=5.
REQ-028 The bench SHALL compare every result against a reference model over all 32-bit F(k) values and F(k)+1.
